// File: rtl/gtr_nibble_packer_if.sv
// Nibble-in / word-out stream bundle between a nibble producer, the packer and iiprng.
// The slave modport is the packer's view, the master modport is the producer/consumer view.
interface gtr_nibble_packer_if #(
   parameter int unsigned NIB_W = 4,
   parameter int unsigned CNT_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NIB_W-1:0]         in_nib;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [1:3][3:2][0:3]     out_word;
   logic [2:0]               out_nibs;
   logic [CNT_W-1:0]         word_cnt;

   modport slave (
      input  in_valid, in_nib, in_last, out_ready,
      output in_ready, out_valid, out_word, out_nibs, word_cnt
   );

   modport master (
      output in_valid, in_nib, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_nibs, word_cnt
   );
endinterface

// File: rtl/gtr_nibble_packer.sv
// Packs 4-bit nibbles MSB-first into 24-bit iiprng words, with early close on in_last,
// and queues finished words in a small shift FIFO whose head register drives the outputs.
module gtr_nibble_packer #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_W      = 16
) (
   input logic               clk,
   input logic               rst,
   gtr_nibble_packer_if.slave pk_io
);
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned NIBS   = 6;
   localparam int unsigned WORD_W = NIB_W * NIBS;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);

   typedef logic [1:3][3:2][0:3] word_t;

   word_t              acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   word_t              mem_q  [FIFO_DEPTH];
   word_t              mem_d  [FIFO_DEPTH];
   logic [2:0]         nibs_q [FIFO_DEPTH];
   logic [2:0]         nibs_d [FIFO_DEPTH];
   logic [CW-1:0]      cnt_q, cnt_d, cnt_sh;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic               accept, complete, pop;
   logic [WORD_W-1:0]  flat;

   // Accumulator, shift FIFO (entry 0 is head) and statistics next-state
   always_comb begin
      acc_d       = acc_q;
      idx_d       = idx_q;
      mem_d       = mem_q;
      nibs_d      = nibs_q;
      wcnt_d      = wcnt_q;
      flat        = WORD_W'(acc_q);
      accept      = pk_io.in_valid & in_ready_q;
      complete    = accept & ((idx_q == IDX_W'(NIBS - 1)) | pk_io.in_last);
      pop         = out_valid_q & pk_io.out_ready;
      cnt_sh      = cnt_q;

      // Slot k lands at packed index [1 + k/2][3 - k%2], i.e. k-th nibble from the MSB
      for (int unsigned k = 0; k < NIBS; k++) begin
         if (idx_q == IDX_W'(k)) flat[(NIBS - 1 - k) * NIB_W +: NIB_W] = pk_io.in_nib;
      end

      if (accept) begin
         if (complete) begin
            acc_d = '0;
            idx_d = '0;
         end else begin
            acc_d = word_t'(flat);
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (pop) begin
         for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
            mem_d[i]  = mem_q[i + 1];
            nibs_d[i] = nibs_q[i + 1];
         end
         mem_d[FIFO_DEPTH - 1]  = '0;
         nibs_d[FIFO_DEPTH - 1] = '0;
         cnt_sh = cnt_q - CW'(1);
      end

      cnt_d = cnt_sh;
      if (complete) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (cnt_sh == CW'(i)) begin
               mem_d[i]  = word_t'(flat);
               nibs_d[i] = idx_q + 3'd1;
            end
         end
         cnt_d  = cnt_sh + CW'(1);
         wcnt_d = wcnt_q + CNT_W'(1);
      end

      // Ready looks only at registered occupancy, so out_ready never reaches in_ready combinationally
      in_ready_d  = (cnt_d != CW'(FIFO_DEPTH));
      out_valid_d = (cnt_d != CW'(0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         wcnt_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i]  <= '0;
            nibs_q[i] <= '0;
         end
      end else begin
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         wcnt_q      <= wcnt_d;
         mem_q       <= mem_d;
         nibs_q      <= nibs_d;
      end
   end

   assign pk_io.in_ready  = in_ready_q;
   assign pk_io.out_valid = out_valid_q;
   assign pk_io.out_word  = mem_q[0];
   assign pk_io.out_nibs  = nibs_q[0];
   assign pk_io.word_cnt  = wcnt_q;

endmodule
